// File: rtl/ones_comp_checksum.sv
// Sequential ones'-complement checksum accumulator with valid/ready word input
// and a result held until acknowledged.
module ones_comp_checksum #(
    parameter int WIDTH   = 4,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_last,
    output logic               sum_valid,
    output logic [WIDTH-1:0]   sum_out,
    output logic [WIDTH-1:0]   acc_out,
    output logic [COUNT_W-1:0] word_count,
    input  logic               sum_ack
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   sum_q;
    logic [COUNT_W-1:0] cnt_q;

    logic               beat;
    logic [WIDTH-1:0]   acc_d;
    logic [COUNT_W-1:0] cnt_d;

    // End-around carry add; all-ones is kept as a legal "negative zero".
    function automatic logic [WIDTH-1:0] oc_add(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [WIDTH:0] t;
        t = {1'b0, a} + {1'b0, b};
        return t[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, t[WIDTH]};
    endfunction

    assign beat  = in_valid && (state_q == ACCUM);
    assign acc_d = oc_add(acc_q, in_data);
    assign cnt_d = (cnt_q == {COUNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_d;
                        if (in_last) begin
                            sum_q   <= ~acc_d;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (sum_ack) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Handshake flags decode straight from the registered state.
    assign in_ready   = (state_q == ACCUM);
    assign sum_valid  = (state_q == DONE);
    assign sum_out    = sum_q;
    assign acc_out    = acc_q;
    assign word_count = cnt_q;

endmodule
